// File: rtl/pwrseq_request_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwrseq_request_ctrl_if
// Brief    : Request sources and sequencer command/status for the power-request
//            controller.
// Revision : 1.0
// ============================================================================
interface pwrseq_request_ctrl_if;
   logic       sys_sw_in_n;
   logic       wake_n;
   logic       xr_ps_en;
   logic       pch_thermtrip_n;
   logic       cpu_reboot;
   logic       cpu_power_off;
   logic       seq_steady;
   logic       seq_off;
   logic       any_lim_recov_fault;
   logic       any_non_recov_fault;
   logic       turn_system_on;
   logic       force_pwrbtn_n;
   logic       cpld_latch_sys_off;
   logic [3:0] retry_cnt;
   logic [2:0] ctrl_state;

   modport master (
      output sys_sw_in_n, wake_n, xr_ps_en, pch_thermtrip_n, cpu_reboot,
             cpu_power_off, seq_steady, seq_off, any_lim_recov_fault,
             any_non_recov_fault,
      input  turn_system_on, force_pwrbtn_n, cpld_latch_sys_off, retry_cnt,
             ctrl_state
   );

   modport slave (
      input  sys_sw_in_n, wake_n, xr_ps_en, pch_thermtrip_n, cpu_reboot,
             cpu_power_off, seq_steady, seq_off, any_lim_recov_fault,
             any_non_recov_fault,
      output turn_system_on, force_pwrbtn_n, cpld_latch_sys_off, retry_cnt,
             ctrl_state
   );
endinterface
`default_nettype wire

// File: rtl/pwrseq_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwrseq_request_ctrl
// Brief    : Arbitrates power requests into turn_system_on; schedules reboot
//            off-time, limited-recovery retries and fault latch-off.
// Revision : 1.0
// ============================================================================
module pwrseq_request_ctrl #(
   parameter int BTN_DEBOUNCE_TICKS = 40,
   parameter int BTN_OVERRIDE_TICKS = 8,
   parameter int REBOOT_OFF_TICKS   = 4,
   parameter int RETRY_WAIT_TICKS   = 2,
   parameter int MAX_RETRY          = 2
) (
   input  wire logic           clk,
   input  wire logic           reset,
   input  wire logic           t512us,
   input  wire logic           t512ms,
   pwrseq_request_ctrl_if.slave bus
);

   localparam int c_NSYNC   = 10;
   localparam int c_DB_W    = $clog2(BTN_DEBOUNCE_TICKS + 1);
   localparam int c_LP_W    = $clog2(BTN_OVERRIDE_TICKS + 1);
   localparam int c_TMR_MAX = (REBOOT_OFF_TICKS > RETRY_WAIT_TICKS) ?
                              REBOOT_OFF_TICKS : RETRY_WAIT_TICKS;
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
   // Synchronizers idle at the inactive level of each source
   localparam logic [c_NSYNC-1:0] c_SYNC_RST = 10'b00_0010_1011;

   typedef enum logic [2:0] {
      S_IDLE_OFF   = 3'd0,
      S_ON_REQ     = 3'd1,
      S_ON         = 3'd2,
      S_OFF_REQ    = 3'd3,
      S_CYCLE_WAIT = 3'd4,
      S_RETRY_WAIT = 3'd5,
      S_LATCH_OFF  = 3'd6
   } state_t;

   logic [c_NSYNC-1:0] w_async_in;
   logic [c_NSYNC-1:0] r_sync1;
   logic [c_NSYNC-1:0] r_sync2;

   assign w_async_in = {bus.any_non_recov_fault, bus.any_lim_recov_fault,
                        bus.seq_off, bus.seq_steady, bus.cpu_power_off,
                        bus.cpu_reboot, bus.pch_thermtrip_n, bus.xr_ps_en,
                        bus.wake_n, bus.sys_sw_in_n};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= c_SYNC_RST;
         r_sync2 <= c_SYNC_RST;
      end else begin
         r_sync1 <= w_async_in;
         r_sync2 <= r_sync1;
      end
   end

   logic w_btn_n, w_wake_n, w_xr_ps_en, w_therm_n, w_reboot, w_pwr_off_n;
   logic w_seq_steady, w_seq_off, w_lim_fault, w_non_fault;

   assign {w_non_fault, w_lim_fault, w_seq_off, w_seq_steady, w_pwr_off_n,
           w_reboot, w_therm_n, w_xr_ps_en, w_wake_n, w_btn_n} = r_sync2;

   logic              r_btn_db;
   logic [c_DB_W-1:0] r_db_cnt;
   logic              r_btn_press;
   logic [c_LP_W-1:0] r_lp_cnt;
   logic              r_btn_long;
   logic              r_reboot_d;
   logic              w_reboot_evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_db    <= 1'b1;
         r_db_cnt    <= '0;
         r_btn_press <= 1'b0;
      end else begin
         r_btn_press <= 1'b0;
         if (t512us) begin
            if (w_btn_n != r_btn_db) begin
               if (r_db_cnt == c_DB_W'(BTN_DEBOUNCE_TICKS - 1)) begin
                  r_btn_db    <= w_btn_n;
                  r_db_cnt    <= '0;
                  r_btn_press <= ~w_btn_n;
               end else begin
                  r_db_cnt <= r_db_cnt + c_DB_W'(1);
               end
            end else begin
               r_db_cnt <= '0;
            end
         end
      end
   end

   // Counter saturates at the override value so btn_long fires once per press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lp_cnt   <= '0;
         r_btn_long <= 1'b0;
         r_reboot_d <= 1'b0;
      end else begin
         r_btn_long <= 1'b0;
         r_reboot_d <= w_reboot;
         if (r_btn_db) begin
            r_lp_cnt <= '0;
         end else if (t512ms && (r_lp_cnt != c_LP_W'(BTN_OVERRIDE_TICKS))) begin
            r_lp_cnt <= r_lp_cnt + c_LP_W'(1);
            if (r_lp_cnt == c_LP_W'(BTN_OVERRIDE_TICKS - 1)) begin
               r_btn_long <= 1'b1;
            end
         end
      end
   end

   assign w_reboot_evt = w_reboot & ~r_reboot_d;

   state_t             r_state, w_state_nxt;
   logic [3:0]         r_retry, w_retry_nxt;
   logic               r_cycle, w_cycle_nxt;
   logic [c_TMR_W-1:0] r_tmr, w_tmr_nxt;
   logic               r_turn_on, r_force_n, r_latch_off;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE_OFF;
         r_retry     <= '0;
         r_cycle     <= 1'b0;
         r_tmr       <= '0;
         r_turn_on   <= 1'b0;
         r_force_n   <= 1'b1;
         r_latch_off <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_retry     <= w_retry_nxt;
         r_cycle     <= w_cycle_nxt;
         r_tmr       <= w_tmr_nxt;
         r_turn_on   <= (w_state_nxt == S_ON_REQ) || (w_state_nxt == S_ON);
         r_force_n   <= (w_state_nxt != S_LATCH_OFF);
         r_latch_off <= (w_state_nxt == S_LATCH_OFF);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_cycle_nxt = r_cycle;
      w_tmr_nxt   = r_tmr;

      case (r_state)
         S_IDLE_OFF: begin
            if (w_xr_ps_en && w_seq_off && (r_btn_press || !w_wake_n)) begin
               w_state_nxt = S_ON_REQ;
            end
         end
         S_ON_REQ, S_ON, S_OFF_REQ: begin
            if (w_non_fault) begin
               w_state_nxt = S_LATCH_OFF;
            end else if (w_lim_fault) begin
               if (r_retry < 4'(MAX_RETRY)) begin
                  w_state_nxt = S_RETRY_WAIT;
                  if (r_retry != 4'd15) begin
                     w_retry_nxt = r_retry + 4'd1;
                  end
               end else begin
                  w_state_nxt = S_LATCH_OFF;
               end
            end else begin
               case (r_state)
                  S_ON_REQ: begin
                     if (w_seq_steady) begin
                        w_state_nxt = S_ON;
                     end else if (!w_xr_ps_en) begin
                        w_state_nxt = S_OFF_REQ;
                        w_cycle_nxt = 1'b0;
                     end
                  end
                  S_ON: begin
                     // A short press in ON belongs to the PCH, not to us
                     if (!w_therm_n || !w_pwr_off_n || r_btn_long || !w_xr_ps_en) begin
                        w_state_nxt = S_OFF_REQ;
                        w_cycle_nxt = 1'b0;
                     end else if (w_reboot_evt) begin
                        w_state_nxt = S_OFF_REQ;
                        w_cycle_nxt = 1'b1;
                     end
                  end
                  default: begin
                     if (w_seq_off) begin
                        if (r_cycle) begin
                           w_state_nxt = S_CYCLE_WAIT;
                        end else begin
                           w_state_nxt = S_IDLE_OFF;
                           w_retry_nxt = '0;
                        end
                     end
                  end
               endcase
            end
         end
         S_CYCLE_WAIT: begin
            if (r_tmr >= c_TMR_W'(REBOOT_OFF_TICKS)) begin
               w_state_nxt = S_ON_REQ;
               w_cycle_nxt = 1'b0;
            end else if (t512ms) begin
               w_tmr_nxt = r_tmr + c_TMR_W'(1);
            end
         end
         S_RETRY_WAIT: begin
            if (r_tmr >= c_TMR_W'(RETRY_WAIT_TICKS)) begin
               w_state_nxt = w_xr_ps_en ? S_ON_REQ : S_IDLE_OFF;
            end else if (t512ms && w_seq_off) begin
               w_tmr_nxt = r_tmr + c_TMR_W'(1);
            end
         end
         S_LATCH_OFF: begin
            if (r_btn_press && w_seq_off && !w_non_fault && !w_lim_fault) begin
               w_state_nxt = S_IDLE_OFF;
               w_retry_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE_OFF;
         end
      endcase

      if (w_state_nxt != r_state) begin
         w_tmr_nxt = '0;
      end
   end

   assign bus.turn_system_on     = r_turn_on;
   assign bus.force_pwrbtn_n     = r_force_n;
   assign bus.cpld_latch_sys_off = r_latch_off;
   assign bus.retry_cnt          = r_retry;
   assign bus.ctrl_state         = r_state;

endmodule
`default_nettype wire
